// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ID/EX bundle type, control-bit positions and bubble constant
package pipe_pkg;
  localparam int ID_XLEN = 32;
  localparam int ID_CTRL_W = 12;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD = 1;
  typedef struct packed {
    logic [ID_XLEN-1:0] pc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [ID_XLEN-1:0] rs1_data;
    logic [ID_XLEN-1:0] rs2_data;
    logic [ID_XLEN-1:0] imm;
    logic [ID_CTRL_W-1:0] ctrl;
  } id_ex_t;
  localparam id_ex_t BUBBLE = '0;
endpackage

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use detection and mem_stall > flush > load-use priority decode
module hazard_ctrl (
  input  logic       rst,
  input  logic       valid_d,
  input  logic       valid_e,
  input  logic       memread_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       flush_e,
  input  logic       mem_stall,
  output logic       freeze,
  output logic       bubble,
  output logic       hold_fd,
  output logic       flush_fd,
  output logic       stall_inc,
  output logic       flush_inc
);
  logic load_use;
  assign load_use = valid_d & valid_e & memread_e & (rd_e != 5'd0) & ((rs1_d == rd_e) | (rs2_d == rd_e));
  assign freeze = mem_stall;
  assign flush_inc = !mem_stall & flush_e;
  assign stall_inc = !mem_stall & !flush_e & load_use;
  assign bubble = flush_inc | stall_inc;
  assign hold_fd = !rst & (mem_stall | stall_inc);
  assign flush_fd = !rst & flush_inc;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard, flush, stall control and event counters
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = ID_XLEN,
  parameter int CTRL_W = ID_CTRL_W,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [XLEN-1:0]   rs1_data_d,
  input  logic [XLEN-1:0]   rs2_data_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              flush_e,
  input  logic              mem_stall,
  output logic              valid_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [XLEN-1:0]   rs1_data_e,
  output logic [XLEN-1:0]   rs2_data_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic              RegWrite_e,
  output logic              MemRead_e,
  output logic              hold_fd,
  output logic              flush_fd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  id_ex_t e, cap;
  logic freeze, bubble, stall_inc, flush_inc;
  hazard_ctrl u_hazard (
    .rst(rst), .valid_d(valid_d), .valid_e(valid_e), .memread_e(MemRead_e), .rd_e(rd_e),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .flush_e(flush_e), .mem_stall(mem_stall),
    .freeze(freeze), .bubble(bubble), .hold_fd(hold_fd), .flush_fd(flush_fd),
    .stall_inc(stall_inc), .flush_inc(flush_inc)
  );
  always_comb begin
    cap = '{pc: pc_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d, rs1_data: rs1_data_d,
            rs2_data: rs2_data_d, imm: imm_d, ctrl: valid_d ? ctrl_d : '0};
    cap.ctrl[CTRL_REGWRITE] = cap.ctrl[CTRL_REGWRITE] & (rd_d != 5'd0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e <= BUBBLE;
      valid_e <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      e <= bubble ? BUBBLE : cap;
      valid_e <= !bubble & valid_d;
      stall_cnt <= stall_cnt + CNT_W'(stall_inc);
      flush_cnt <= flush_cnt + CNT_W'(flush_inc);
    end
  end
  assign pc_e = e.pc;
  assign rs1_e = e.rs1;
  assign rs2_e = e.rs2;
  assign rd_e = e.rd;
  assign rs1_data_e = e.rs1_data;
  assign rs2_data_e = e.rs2_data;
  assign imm_e = e.imm;
  assign ctrl_e = e.ctrl;
  assign RegWrite_e = e.ctrl[CTRL_REGWRITE];
  assign MemRead_e = e.ctrl[CTRL_MEMREAD];
endmodule
